vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 640x480 sync block.
//  Produces sync, blanking, pixel coordinates and line/frame start strobes for any VESA-style mode.
//  Adds a pixel clock-enable, programmable sync polarity and registered, skew-free outputs.
//  Sits between the pixel clock domain and the framebuffer/character renderers.
// PARAMETERS
//  CNT_W        10   width of the x/y counters and coordinate outputs
//  H_DISPLAY   640   visible pixels per line
//  H_FRONT      16   horizontal front porch, pixels
//  H_SYNC       96   horizontal sync pulse, pixels
//  H_BACK       48   horizontal back porch, pixels
//  V_DISPLAY   480   visible lines
//  V_FRONT      10   vertical front porch, lines
//  V_SYNC        2   vertical sync pulse, lines
//  V_BACK       33   vertical back porch, lines
//  H_SYNC_POL    0   hsync active level (0 = active low)
//  V_SYNC_POL    0   vsync active level (0 = active low)
// PORTS
//  clk_pixel    in   1      pixel clock
//  rst          in   1      reset, synchronous, active-high
//  pix_ce       in   1      pixel advance enable; counters step only when high
//  hsync        out  1      horizontal sync, level per H_SYNC_POL
//  vsync        out  1      vertical sync, level per V_SYNC_POL
//  video_on     out  1      high inside the visible area
//  hblank       out  1      high when x >= H_DISPLAY
//  vblank       out  1      high when y >= V_DISPLAY
//  pixel_x      out  CNT_W  current column
//  pixel_y      out  CNT_W  current line
//  line_start   out  1      1-cycle strobe on x wrapping to 0
//  frame_start  out  1      1-cycle strobe on (x,y) wrapping to (0,0)
//  frame_count  out  8      frames completed, mod 256 (only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
//  - H_TOTAL = sum of the H_* terms; V_TOTAL = sum of the V_* terms. Elaboration $error if H_TOTAL-1 or V_TOTAL-1 >= 2**CNT_W.
//  - Per-axis phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Each transition occurs when the axis count crosses the phase boundary.
//  - x axis steps on every pix_ce-qualified edge. y axis steps only on the x wrap from H_TOTAL-1 to 0.
//  - y wraps from V_TOTAL-1 to 0 on the same edge as the final x wrap.
//  - pix_ce low: counters, phases and all level outputs hold their values.
//  - All outputs are registers decoded from the next counter state. Zero relative skew: every flag matches pixel_x/pixel_y in the same cycle.
//  - hsync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; vsync likewise on y.
//  - video_on = !hblank && !vblank.
//  - line_start is high for exactly one clk_pixel cycle after the ce edge on which x became 0. It clears on the next clock even if pix_ce is low.
//  - frame_start is the same strobe for the (0,0) wrap. line_start is also high in that cycle.
//  - Reset values: pixel_x=0, pixel_y=0, phases ACTIVE, video_on=1, hblank=0, vblank=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, line_start=0, frame_start=0, frame_count=0.
//  - The first frame_start therefore fires at the end of the first frame.
//  - rst has priority over pix_ce. Reset mid-frame returns to the reset state on the next edge, with no strobes.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined: frame_count port exists. It increments on every frame_start and wraps 255->0.
//  VGA_FRAME_CNT_EN undefined: the port and its register are absent; all other behaviour is identical.
// STRUCTURE
//  vga_timing_pkg: phase enum (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK) and 640x480@60 default constants.
//  Sub-module vga_axis_counter (count, wrap, phase FSM, sync/blank decode), instantiated twice: h axis and v axis.
//  The v instance uses the h wrap as its step enable.
// TESTING
//  1. Default params, rst 1 cycle, pix_ce=1 -> x=0, y=0, video_on=1, hsync=1, vsync=1.
//  2. 800 ce cycles -> line_start for 1 cycle with x=0, y=1. hsync low for exactly x=656..751 (96 cycles). video_on low for x>=640.
//  3. 420000 ce cycles -> frame_start=1 and line_start=1 with (0,0). vsync low for lines 490..491 only. vblank high for y 480..524.
//  4. pix_ce toggled 1,0,1,0 -> x advances every 2nd clock. Strobes stay 1 clock wide. Outputs hold while pix_ce=0.
//  5. rst asserted at (300,200) with pix_ce=1 -> next cycle (0,0), reset values, no line_start/frame_start.
//  6. 1280x720: CNT_W=11, H 1280/110/40/220, V 720/5/5/20, pols=1 -> hsync high for x=1390..1429, vsync high for y=725..729.
//     With VGA_FRAME_CNT_EN, frame_count reaches 2 after 2 frames and wraps 255->0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: the per-axis phase
// encoding, the 640x480@60 default mode, and a sync level helper.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    localparam int DEF_CNT_W     = 10;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Drive the active level while in the sync phase, the inactive level otherwise.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, ACTIVE/FRONT/SYNC/BACK phase
// FSM, and registered sync/blank flags decoded from the next count so they
// line up with the count register.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W    = DEF_CNT_W,
    parameter int   DISPLAY  = DEF_H_DISPLAY,
    parameter int   FRONT    = DEF_H_FRONT,
    parameter int   SYNC     = DEF_H_SYNC,
    parameter int   BACK     = DEF_H_BACK,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             blank,
    output logic             blank_next,
    output logic             wrap
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] ZERO        = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(DISPLAY);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(DISPLAY + FRONT);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(DISPLAY + FRONT + SYNC);

    if ((TOTAL - 1) >= (2 ** CNT_W)) begin : g_range_check
        $error("vga_axis_counter: total of %0d does not fit in %0d bits", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] count_q, count_d;
    phase_t           phase_q, phase_d;
    logic             sync_q, sync_d;
    logic             blank_q, blank_d;
    logic             wrap_s;

    // Next count, wrap detect and phase transitions on boundary crossings.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap_s  = 1'b0;
        if (step) begin
            if (count_q == LAST) begin
                count_d = ZERO;
                wrap_s  = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
        case (phase_q)
            PH_ACTIVE: if (count_d == FRONT_START) phase_d = PH_FRONT;  else phase_d = PH_ACTIVE;
            PH_FRONT:  if (count_d == SYNC_START)  phase_d = PH_SYNC;   else phase_d = PH_FRONT;
            PH_SYNC:   if (count_d == BACK_START)  phase_d = PH_BACK;   else phase_d = PH_SYNC;
            PH_BACK:   if (count_d == ZERO)        phase_d = PH_ACTIVE; else phase_d = PH_BACK;
            default:   phase_d = PH_ACTIVE;
        endcase
        sync_d  = sync_level(phase_d == PH_SYNC, SYNC_POL);
        blank_d = (phase_d != PH_ACTIVE);
    end

    // Axis state registers; reset parks the axis at 0 in the visible phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
            phase_q <= PH_ACTIVE;
            sync_q  <= ~SYNC_POL;
            blank_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            sync_q  <= sync_d;
            blank_q <= blank_d;
        end
    end

    assign count      = count_q;
    assign sync       = sync_q;
    assign blank      = blank_q;
    assign blank_next = blank_d;
    assign wrap       = wrap_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style raster timing generator. Two axis counters (x
// steps on pix_ce, y steps on the x wrap) feed registered sync, blank,
// coordinate and strobe outputs that are all aligned to the same cycle.
// Optional build macro: VGA_FRAME_CNT_EN adds the 8-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   H_DISPLAY  = DEF_H_DISPLAY,
    parameter int   H_FRONT    = DEF_H_FRONT,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BACK     = DEF_H_BACK,
    parameter int   V_DISPLAY  = DEF_V_DISPLAY,
    parameter int   V_FRONT    = DEF_V_FRONT,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BACK     = DEF_V_BACK,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic             clk_pixel,
    input  logic             rst,
    input  logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             hblank,
    output logic             vblank,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    logic h_blank_d, v_blank_d;
    logic h_wrap_s, v_wrap_s;

    vga_axis_counter #(
        .CNT_W(CNT_W), .DISPLAY(H_DISPLAY), .FRONT(H_FRONT),
        .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(H_SYNC_POL)
    ) u_h_axis (
        .clk(clk_pixel), .rst(rst), .step(pix_ce),
        .count(pixel_x), .sync(hsync), .blank(hblank),
        .blank_next(h_blank_d), .wrap(h_wrap_s)
    );

    // The y axis advances only on the x wrap, which already includes pix_ce.
    vga_axis_counter #(
        .CNT_W(CNT_W), .DISPLAY(V_DISPLAY), .FRONT(V_FRONT),
        .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(V_SYNC_POL)
    ) u_v_axis (
        .clk(clk_pixel), .rst(rst), .step(h_wrap_s),
        .count(pixel_y), .sync(vsync), .blank(vblank),
        .blank_next(v_blank_d), .wrap(v_wrap_s)
    );

    logic video_on_q, video_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Visible flag and wrap strobes computed from the next axis state.
    always_comb begin
        video_on_d    = ~h_blank_d & ~v_blank_d;
        line_start_d  = h_wrap_s;
        frame_start_d = v_wrap_s;
    end

    // Strobes fall back to 0 on any clock without a wrap, even with pix_ce low.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            video_on_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_count_q, frame_count_d;

    // Completed-frame counter, wrapping naturally at 8 bits.
    always_comb begin
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 8'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line
// timing, pix_ce gating and reset; a tiny 15x8 instance for frame-level
// behaviour; a 1280x720 active-high instance for a full line.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- default 640x480 instance ----------------
    logic rst_d, ce_d;
    logic hs_d, vs_d, von_d, hb_d, vb_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_d;
`endif

    vga_timing_gen u_def (
        .clk_pixel(clk), .rst(rst_d), .pix_ce(ce_d),
        .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .hblank(hb_d), .vblank(vb_d),
        .pixel_x(x_d), .pixel_y(y_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_d)
`endif
    );

    // ---------------- tiny 15x8 instance, vsync active high ----------------
    logic rst_s, ce_s;
    logic hs_s, vs_s, von_s, hb_s, vb_s, ls_s, fs_s;
    logic [4:0] x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_s;
`endif

    vga_timing_gen #(
        .CNT_W(5), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) u_small (
        .clk_pixel(clk), .rst(rst_s), .pix_ce(ce_s),
        .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .hblank(hb_s), .vblank(vb_s),
        .pixel_x(x_s), .pixel_y(y_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_s)
`endif
    );

    // ---------------- 1280x720 instance, both syncs active high ----------------
    logic rst_h, ce_h;
    logic hs_h, vs_h, von_h, hb_h, vb_h, ls_h, fs_h;
    logic [10:0] x_h, y_h;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_h;
`endif

    vga_timing_gen #(
        .CNT_W(11), .H_DISPLAY(1280), .H_FRONT(110), .H_SYNC(40), .H_BACK(220),
        .V_DISPLAY(720), .V_FRONT(5), .V_SYNC(5), .V_BACK(20),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_hd (
        .clk_pixel(clk), .rst(rst_h), .pix_ce(ce_h),
        .hsync(hs_h), .vsync(vs_h), .video_on(von_h), .hblank(hb_h), .vblank(vb_h),
        .pixel_x(x_h), .pixel_y(y_h), .line_start(ls_h), .frame_start(fs_h)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_h)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int pos_bad, vid_bad, hb_bad, vb_bad, vs_bad, hs_bad, ls_bad, fs_bad;
    int hs_cnt, hs_first, hs_last, vs_cnt, ls_cnt, fs_cnt, n_ce;
    int ex, ey;

    initial begin
        rst_d = 1'b1; rst_s = 1'b1; rst_h = 1'b1;
        ce_d  = 1'b1; ce_s  = 1'b1; ce_h  = 1'b1;
        cyc();
        rst_d = 1'b0; rst_s = 1'b0; rst_h = 1'b0;
        ce_s  = 1'b0; ce_h  = 1'b0;

        // Reset state
        check("rst_x",        64'(x_d),   64'd0);
        check("rst_y",        64'(y_d),   64'd0);
        check("rst_video_on", 64'(von_d), 64'd1);
        check("rst_hsync",    64'(hs_d),  64'd1);
        check("rst_vsync",    64'(vs_d),  64'd1);
        check("rst_hblank",   64'(hb_d),  64'd0);
        check("rst_vblank",   64'(vb_d),  64'd0);
        check("rst_ls",       64'(ls_d),  64'd0);
        check("rst_fs",       64'(fs_d),  64'd0);
        check("rst_hd_hsync", 64'(hs_h),  64'd0);
        check("rst_hd_vsync", 64'(vs_h),  64'd0);
        check("rst_sm_vsync", 64'(vs_s),  64'd0);
`ifdef VGA_FRAME_CNT_EN
        check("rst_fc",       64'(fc_d),  64'd0);
`endif

        // One full 800-pixel line on the default mode
        pos_bad = 0; vid_bad = 0; hb_bad = 0; ls_bad = 0; fs_bad = 0;
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 1; i <= 800; i++) begin
            cyc();
            ex = i % 800;
            ey = i / 800;
            if (int'(x_d) != ex || int'(y_d) != ey) pos_bad++;
            if (hs_d === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = ex;
                hs_last = ex;
            end
            if (von_d !== (ex < 640))  vid_bad++;
            if (hb_d  !== (ex >= 640)) hb_bad++;
            if (ls_d  !== (ex == 0))   ls_bad++;
            if (fs_d  !== 1'b0)        fs_bad++;
        end
        check("line_pos_bad",   64'(pos_bad),  64'd0);
        check("line_hs_cnt",    64'(hs_cnt),   64'd96);
        check("line_hs_first",  64'(hs_first), 64'd656);
        check("line_hs_last",   64'(hs_last),  64'd751);
        check("line_video_bad", 64'(vid_bad),  64'd0);
        check("line_hblank_bad",64'(hb_bad),   64'd0);
        check("line_ls_bad",    64'(ls_bad),   64'd0);
        check("line_fs_bad",    64'(fs_bad),   64'd0);
        check("line_end_x",     64'(x_d),      64'd0);
        check("line_end_y",     64'(y_d),      64'd1);
        check("line_end_ls",    64'(ls_d),     64'd1);
        check("line_end_vsync", 64'(vs_d),     64'd1);

        // pix_ce low: strobe clears, position holds
        ce_d = 1'b0;
        cyc();
        check("ce0_ls_clear", 64'(ls_d), 64'd0);
        check("ce0_x_hold",   64'(x_d),  64'd0);
        check("ce0_y_hold",   64'(y_d),  64'd1);

        // pix_ce toggling 1,0,1,0: x advances every second clock
        n_ce = 0;
        for (int k = 0; k < 8; k++) begin
            ce_d = ((k % 2) == 0);
            cyc();
            if ((k % 2) == 0) n_ce++;
            check("ce_toggle_x",  64'(x_d),  64'(n_ce));
            check("ce_toggle_ls", 64'(ls_d), 64'd0);
        end

        // Move into the hsync pulse of line 1, then reset mid-line
        ce_d = 1'b1;
        repeat (696) cyc();
        check("pre_rst_x",     64'(x_d),   64'd700);
        check("pre_rst_hsync", 64'(hs_d),  64'd0);
        check("pre_rst_von",   64'(von_d), 64'd0);
        rst_d = 1'b1;
        cyc();
        rst_d = 1'b0;
        check("midrst_x",      64'(x_d),   64'd0);
        check("midrst_y",      64'(y_d),   64'd0);
        check("midrst_hsync",  64'(hs_d),  64'd1);
        check("midrst_von",    64'(von_d), 64'd1);
        check("midrst_hblank", 64'(hb_d),  64'd0);
        check("midrst_ls",     64'(ls_d),  64'd0);
        check("midrst_fs",     64'(fs_d),  64'd0);

        // Tiny mode: one full 15x8 frame
        ce_s = 1'b1;
        pos_bad = 0; vs_bad = 0; vb_bad = 0; vid_bad = 0; hs_bad = 0;
        vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 1; i <= 120; i++) begin
            cyc();
            ex = i % 15;
            ey = (i / 15) % 8;
            if (int'(x_s) != ex || int'(y_s) != ey) pos_bad++;
            if (vs_s  !== (ey >= 5 && ey <= 6))    vs_bad++;
            if (vs_s  === 1'b1)                    vs_cnt++;
            if (vb_s  !== (ey >= 4))               vb_bad++;
            if (von_s !== (ex < 8 && ey < 4))      vid_bad++;
            if (hs_s  !== !(ex >= 10 && ex <= 12)) hs_bad++;
            if (ls_s  === 1'b1)                    ls_cnt++;
            if (fs_s  === 1'b1)                    fs_cnt++;
        end
        check("frm_pos_bad",  64'(pos_bad), 64'd0);
        check("frm_vs_bad",   64'(vs_bad),  64'd0);
        check("frm_vs_cnt",   64'(vs_cnt),  64'd30);
        check("frm_vb_bad",   64'(vb_bad),  64'd0);
        check("frm_von_bad",  64'(vid_bad), 64'd0);
        check("frm_hs_bad",   64'(hs_bad),  64'd0);
        check("frm_ls_cnt",   64'(ls_cnt),  64'd8);
        check("frm_fs_cnt",   64'(fs_cnt),  64'd1);
        check("frm_end_x",    64'(x_s),     64'd0);
        check("frm_end_y",    64'(y_s),     64'd0);
        check("frm_end_fs",   64'(fs_s),    64'd1);
        check("frm_end_ls",   64'(ls_s),    64'd1);
`ifdef VGA_FRAME_CNT_EN
        check("frm_fc_1",     64'(fc_s),    64'd1);
`endif
        cyc();
        check("frm_fs_clear", 64'(fs_s), 64'd0);
        check("frm_ls_clear", 64'(ls_s), 64'd0);
        check("frm_x1",       64'(x_s),  64'd1);

        // Line wrap with pix_ce gating: strobe stays one clock wide
        repeat (13) cyc();
        ce_s = 1'b0;
        cyc();
        check("gate_x_hold", 64'(x_s),  64'd14);
        check("gate_no_ls",  64'(ls_s), 64'd0);
        ce_s = 1'b1;
        cyc();
        check("gate_wrap_x",  64'(x_s),  64'd0);
        check("gate_wrap_y",  64'(y_s),  64'd1);
        check("gate_wrap_ls", 64'(ls_s), 64'd1);
        check("gate_wrap_fs", 64'(fs_s), 64'd0);
        ce_s = 1'b0;
        cyc();
        check("gate_ls_1clk", 64'(ls_s), 64'd0);
        check("gate_x_held",  64'(x_s),  64'd0);
        ce_s = 1'b1;

        // Reset on the very edge that would wrap the frame: no strobes
        repeat (104) cyc();
        check("last_px_x",  64'(x_s),  64'd14);
        check("last_px_y",  64'(y_s),  64'd7);
        check("last_px_vb", 64'(vb_s), 64'd1);
        rst_s = 1'b1;
        cyc();
        rst_s = 1'b0;
        check("wraprst_x",   64'(x_s),   64'd0);
        check("wraprst_y",   64'(y_s),   64'd0);
        check("wraprst_fs",  64'(fs_s),  64'd0);
        check("wraprst_ls",  64'(ls_s),  64'd0);
        check("wraprst_vs",  64'(vs_s),  64'd0);
        check("wraprst_vb",  64'(vb_s),  64'd0);
        check("wraprst_von", 64'(von_s), 64'd1);
`ifdef VGA_FRAME_CNT_EN
        check("wraprst_fc",  64'(fc_s),  64'd0);
        repeat (240) cyc();
        check("fc_two",      64'(fc_s),  64'd2);
        repeat (253 * 120) cyc();
        check("fc_255",      64'(fc_s),  64'd255);
        repeat (120) cyc();
        check("fc_wrap0",    64'(fc_s),  64'd0);
`endif

        // 1280x720 with active-high syncs: one full line
        ce_h = 1'b1;
        hb_bad = 0; vs_bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 1; i <= 1650; i++) begin
            cyc();
            ex = i % 1650;
            if (hs_h === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = ex;
                hs_last = ex;
            end
            if (hb_h !== (ex >= 1280)) hb_bad++;
            if (vs_h !== 1'b0)         vs_bad++;
        end
        check("hd_hs_cnt",    64'(hs_cnt),   64'd40);
        check("hd_hs_first",  64'(hs_first), 64'd1390);
        check("hd_hs_last",   64'(hs_last),  64'd1429);
        check("hd_hblank_bad",64'(hb_bad),   64'd0);
        check("hd_vsync_bad", 64'(vs_bad),   64'd0);
        check("hd_end_x",     64'(x_h),      64'd0);
        check("hd_end_y",     64'(y_h),      64'd1);
        check("hd_end_ls",    64'(ls_h),     64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
